fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side adapter for the synchronous FIFO. It drains words from the FIFO's `pop`/`rd_data`/`empty` port and presents them as a valid/ready stream, e.g. to the SQRT datapath. It hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer. It sustains one word per cycle, never pops an empty FIFO, and never drops or reorders data.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the FIFO's `WIDTH`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_pop`  out  1  pop strobe to FIFO, one word per asserted cycle.
- `fifo_rd_data`  in  WIDTH  FIFO read data, valid the cycle after `fifo_pop`.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts; transfer when `out_valid & out_ready`.
- `out_data`  out  WIDTH  head word of the output buffer.
- `words_out`  out  16  accepted-transfer counter; exists only with `FIFO_STREAM_READER_STATS_EN`.

## Operation
Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, on `rst_n`.

State is `cnt` (0..2), which is also the FSM: EMPTY (0), ONE (1), TWO (2). Further state:
- `inflight` (1 bit): registered copy of `fifo_pop`.
- Buffer slots `buf0` (head) and `buf1`.

Control:
- `fire = out_valid & out_ready`.
- `fifo_pop = rst_n & ~fifo_empty & (cnt + inflight - fire < 2)`. Arithmetic is 2-bit unsigned. `cnt + inflight` never exceeds 2.
- If `inflight` is 1, `fifo_rd_data` is captured at that clock edge:
  - Into `buf0` if the buffer is empty after this cycle's `fire`.
  - Otherwise into `buf1`.

FSM transitions (`cap` = `inflight`):
- EMPTY: stays EMPTY on no `cap`; goes to ONE on `cap`.
- ONE:
  - `fire` & `cap`: stays ONE, `buf0` <- new word.
  - `fire` only: goes to EMPTY.
  - `cap` only: goes to TWO.
  - Neither: holds.
- TWO:
  - `fire`: goes to ONE, `buf0` <- `buf1`.
  - `cap` is impossible in TWO by the credit rule. The bench asserts this.

Outputs:
- `out_valid = (cnt != 0)`.
- `out_data = buf0`.
- `out_data` stays stable while `out_valid & ~out_ready`.
- Words leave in exactly FIFO order.

Boundary behaviour:
- FIFO empty: `fifo_pop` stays 0. The buffer drains normally.
- Downstream stalled: at most 2 words are popped ahead. The FIFO then holds the rest.
- Simultaneous `fire` and `cap` in ONE: throughput is preserved, with no bubble.
- Reset mid-operation:
  - `cnt` and `inflight` clear immediately, which discards buffered and in-flight words.
  - The FIFO shares `rst_n` and its contents are reset too.

## Timing
- Reset values: `fifo_pop` = 0, `out_valid` = 0, `out_data` = 0, `words_out` = 0.
- Latency: `fifo_pop` in cycle t gives data in `fifo_rd_data` in t+1, and `out_valid` with that word in t+2.
- Non-empty FIFO with `out_ready` = 1: after the first word, one transfer every cycle.
- `fifo_pop` is combinational from `fifo_empty`, `out_ready` and local registers. It has no combinational path from `fifo_rd_data`.
- `out_valid` and `out_data` are registered outputs.

## Configuration
- `FIFO_STREAM_READER_STATS_EN` defined:
  - Port `words_out` exists.
  - It increments by 1 on every `fire`.
  - It saturates at 16'hFFFF.
  - It clears on reset.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
1. Reset, FIFO empty, `out_ready` = 1. Required: `fifo_pop` and `out_valid` stay 0 for 20 cycles.
2. Push 8'hA5 into an empty FIFO. Required: `fifo_pop` pulses one cycle; `out_valid` = 1 with `out_data` = 8'hA5 two cycles later; one transfer; back to EMPTY.
3. Preload 10 words 0..9, hold `out_ready` = 1. Required: 10 consecutive transfers 0..9 with no gaps; exactly 10 pops; `fifo_pop` is never asserted while `fifo_empty` = 1.
4. Preload 10 words, hold `out_ready` = 0 for 8 cycles, then release. Required:
   - Exactly 2 pops during the stall.
   - `out_data` held at 0 throughout.
   - Then words 0..9 delivered in order.
5. Random `out_ready` (50%) with random pushes over 1000 words. Required: scoreboard shows no loss or reorder; the TWO-with-`cap` assertion never fires; with the macro defined, `words_out` = 1000.
6. Assert `rst_n` = 0 mid-stream while in state TWO. Required:
   - `out_valid` and `fifo_pop` drop to 0 asynchronously.
   - After release, new pushes are delivered correctly starting from an empty buffer.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream of fifo_stream_reader.
// master = the reader, slave = FIFO/downstream side.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  out_ready,
    output fifo_pop,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output out_ready,
    input  fifo_pop,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry buffer.
// Optional saturating transfer counter on port words_out when FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [15:0]          words_out
`endif
);

  // The state encoding doubles as the buffer occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             inflight_reg;
  logic [WIDTH-1:0] buf0_reg;
  logic [WIDTH-1:0] buf0_next;
  logic [WIDTH-1:0] buf1_reg;
  logic [WIDTH-1:0] buf1_next;

  logic       fire;
  logic       cap;
  logic       pop;
  logic [1:0] cnt;
  logic [1:0] credit;

  assign cnt  = state_reg;
  assign fire = (state_reg != EMPTY) & bus.out_ready;
  assign cap  = inflight_reg;

  // Slots that will be taken once this cycle's transfer and in-flight word settle;
  // cnt + inflight never exceeds 2 and fire implies cnt >= 1, so no wrap.
  assign credit = cnt + {1'b0, inflight_reg} - {1'b0, fire};
  assign pop    = rst_n & ~bus.fifo_empty & (credit < 2'd2);

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (state_reg != EMPTY);
  assign bus.out_data  = buf0_reg;

  always_comb begin
    state_next = state_reg;
    buf0_next  = buf0_reg;
    buf1_next  = buf1_reg;
    case (state_reg)
      EMPTY: begin
        if (cap) begin
          state_next = ONE;
          buf0_next  = bus.fifo_rd_data;
        end
      end
      ONE: begin
        if (fire && cap) begin
          buf0_next = bus.fifo_rd_data;
        end else if (fire) begin
          state_next = EMPTY;
        end else if (cap) begin
          state_next = TWO;
          buf1_next  = bus.fifo_rd_data;
        end
      end
      TWO: begin
        // The credit rule keeps cap low here, so only a transfer moves the state.
        if (fire) begin
          state_next = ONE;
          buf0_next  = buf1_reg;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      inflight_reg <= 1'b0;
      buf0_reg     <= '0;
      buf1_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= pop;
      buf0_reg     <= buf0_next;
      buf1_reg     <= buf1_next;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0] words_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_out_reg <= 16'h0000;
    end else if (fire && (words_out_reg != 16'hFFFF)) begin
      words_out_reg <= words_out_reg + 16'h0001;
    end
  end

  assign words_out = words_out_reg;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + random bench for fifo_stream_reader against a queue-based FIFO and stream scoreboard.
// Set FIFO_STREAM_READER_STATS_EN to also check words_out.
module tb_fifo_stream_reader;

  logic clk        = 1'b0;
  logic rst_n      = 1'b1;
  logic fifo_rst_n = 1'b1;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(8)) bus ();

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0] words_out;
`endif

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .words_out (words_out)
`endif
  );

  // Behavioural FIFO: registered read, one optional push per cycle.
  // gate hides the contents so words can be preloaded before the reader sees them.
  logic [7:0] fq[$];
  int         fifo_count = 0;
  logic [7:0] rd_data    = 8'h00;
  logic       push_valid = 1'b0;
  logic [7:0] push_data  = 8'h00;
  logic       gate       = 1'b0;

  assign bus.fifo_empty   = (fifo_count == 0) | gate;
  assign bus.fifo_rd_data = rd_data;

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      fq.delete();
      fifo_count <= 0;
      rd_data    <= 8'h00;
    end else begin
      if (bus.fifo_pop && fq.size() != 0) rd_data <= fq.pop_front();
      if (push_valid) fq.push_back(push_data);
      fifo_count <= fq.size();
    end
  end

  // Reference model: words expected downstream in push order, buffered count,
  // word in flight, and the saturating transfer count.
  logic [7:0] exp_q[$];
  int   m_buf = 0;
  int   m_infl = 0;
  int   m_words = 0;
  int   obs_out = 0;
  bit   held_v = 0;
  logic [7:0] held = 8'h00;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pops = 0;
  int fires = 0;
  int last_pop_cyc = 0;
  int last_fire_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, check 1 ns later, advance to the next falling edge.
  task automatic cycle(input bit rdy, input bit pv, input logic [7:0] pd);
    bit fire_m;
    bit pop_m;
    bit fire_o;
    logic [31:0] e;
    bus.out_ready = rdy;
    push_valid    = pv;
    push_data     = pd;
    #1;
    fire_m = (m_buf != 0) && rdy;
    pop_m  = !bus.fifo_empty && ((m_buf + m_infl - int'(fire_m)) < 2);
    fire_o = bus.out_valid & rdy;
    chk("out_valid", {31'h0, bus.out_valid}, {31'h0, m_buf != 0});
    chk("fifo_pop", {31'h0, bus.fifo_pop}, {31'h0, pop_m});
    chk("pop_while_empty", {31'h0, bus.fifo_pop & bus.fifo_empty}, 32'h0);
    if (held_v) chk("stall_hold", {24'h0, bus.out_data}, {24'h0, held});
    obs_out = obs_out + int'(bus.fifo_pop) - int'(fire_o);
    chk("credit_no_cap_in_two", {31'h0, obs_out <= 2}, 32'h1);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("words_out", {16'h0, words_out}, m_words);
`endif
    if (fire_m) begin
      if (exp_q.size() != 0) e = {24'h0, exp_q.pop_front()};
      else e = 32'hDEAD_BEEF;
      chk("data_order", {24'h0, bus.out_data}, e);
      fires++;
      last_fire_cyc = cyc;
      if (m_words < 65535) m_words++;
    end
    if (pop_m) begin
      pops++;
      last_pop_cyc = cyc;
    end
    held_v = (m_buf != 0) && !rdy;
    held   = bus.out_data;
    m_buf  = m_buf + m_infl - int'(fire_m);
    m_infl = int'(pop_m);
    if (pv) exp_q.push_back(pd);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_buf   = 0;
    m_infl  = 0;
    m_words = 0;
    obs_out = 0;
    held_v  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_rst_n = 1'b0;
    push_valid = 1'b0;
    bus.out_ready = 1'b0;
    gate = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    int f0;
    int c0;
    int n_push;
    bit pv;
    logic [7:0] pd;

    bus.out_ready = 1'b0;
    #2;
    do_reset();

    // Reset values
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_data", {24'h0, bus.out_data}, 32'h0);
    chk("rst_fifo_pop", {31'h0, bus.fifo_pop}, 32'h0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("rst_words_out", {16'h0, words_out}, 32'h0);
`endif
    @(negedge clk);

    // 1: empty FIFO, ready high
    p0 = pops;
    repeat (20) cycle(1'b1, 1'b0, 8'h00);
    chk("t1_pops", pops - p0, 0);

    // 2: single word latency
    p0 = pops;
    f0 = fires;
    cycle(1'b1, 1'b1, 8'hA5);
    repeat (5) cycle(1'b1, 1'b0, 8'h00);
    chk("t2_pops", pops - p0, 1);
    chk("t2_fires", fires - f0, 1);
    chk("t2_pop_to_valid", last_fire_cyc - last_pop_cyc, 2);
    chk("t2_back_empty", {31'h0, bus.out_valid}, 32'h0);

    // 3: preload 0..9, full throughput
    gate = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'(i));
    gate = 1'b0;
    p0 = pops;
    f0 = fires;
    c0 = cyc;
    for (int k = 0; k < 40 && (fires - f0) < 10; k++) cycle(1'b1, 1'b0, 8'h00);
    repeat (2) cycle(1'b1, 1'b0, 8'h00);
    chk("t3_fires", fires - f0, 10);
    chk("t3_pops", pops - p0, 10);
    chk("t3_no_gap", last_fire_cyc - c0, 11);

    // 4: stall 8 cycles with preloaded FIFO, then release
    gate = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(i));
    gate = 1'b0;
    p0 = pops;
    f0 = fires;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (bus.out_valid) chk("t4_hold_word0", {24'h0, bus.out_data}, 32'h0);
    end
    chk("t4_stall_pops", pops - p0, 2);
    for (int k = 0; k < 40 && (fires - f0) < 10; k++) cycle(1'b1, 1'b0, 8'h00);
    chk("t4_fires", fires - f0, 10);

    // 5: random traffic, 1000 words
    do_reset();
    f0 = fires;
    n_push = 0;
    for (int k = 0; k < 20000 && (n_push < 1000 || exp_q.size() != 0 || m_buf != 0); k++) begin
      pv = (n_push < 1000) && ($urandom_range(0, 99) < 60);
      pd = 8'($urandom);
      if (pv) n_push++;
      cycle(1'($urandom_range(0, 1)), pv, pd);
    end
    chk("t5_words", fires - f0, 1000);
    chk("t5_leftover", exp_q.size(), 0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("t5_words_out", {16'h0, words_out}, 32'd1000);
`endif

    // 6: reset while holding two words with more waiting in the FIFO
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i));
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    chk("t6_in_two_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("t6_in_two_head", {24'h0, bus.out_data}, 32'h10);
    rst_n = 1'b0;
    #2;
    chk("t6_async_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("t6_async_pop", {31'h0, bus.fifo_pop}, 32'h0);
    chk("t6_async_data", {24'h0, bus.out_data}, 32'h0);
    fifo_rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_rst_n = 1'b1;
    f0 = fires;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i));
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    chk("t6_after_fires", fires - f0, 4);
    chk("t6_after_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
